vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator that replaces the separate horizontal-only sync counter with a single block producing horizontal and vertical sync, a combined display-enable, and pixel coordinates. All porch and pulse lengths, sync polarities and counter width are parameters. A pixel-rate clock enable allows running from a faster system clock, and a synchronous resync input realigns the raster. It sits between the clock/enable source and the pixel/framebuffer logic, feeding the VGA connector directly.

## Interface

- H_SYNCPULSE, 96, horizontal sync pulse length in pixel ticks
- H_BPORCH, 48, horizontal back porch length
- H_DISPLAY, 640, visible pixels per line
- H_FPORCH, 16, horizontal front porch length
- V_SYNCPULSE, 2, vertical sync pulse length in lines
- V_BPORCH, 33, vertical back porch length
- V_DISPLAY, 480, visible lines per frame
- V_FPORCH, 10, vertical front porch length
- HSYNC_POL, 1, hsync level during the pulse; the inactive level is its inverse
- VSYNC_POL, 1, vsync level during the pulse
- CW, 11, width of all counters and coordinates; must hold H_TOTAL-1 and V_TOTAL-1

Ports:

- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  pixel tick; the raster advances one position per clk edge with en=1
- resync  input  1  synchronous restart to position (0,0)
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- display  output  1  1 when both h and v are in their display regions
- h_cnt  output  CW  horizontal position, 0..H_TOTAL-1
- v_cnt  output  CW  vertical position, 0..V_TOTAL-1
- x  output  CW  pixel column, h_cnt-HS0 while display=1, else 0
- y  output  CW  pixel row, v_cnt-VS0 while display=1, else 0
- line_start  output  1  one-cycle pulse when h_cnt has just become 0
- frame_start  output  1  one-cycle pulse when (h_cnt,v_cnt) has just become (0,0)

## Operation

- Derived values:
  - H_TOTAL = H_SYNCPULSE + H_BPORCH + H_DISPLAY + H_FPORCH
  - HS0 = H_SYNCPULSE + H_BPORCH
  - V_TOTAL and VS0 are defined analogously.
- Line order is sync pulse, back porch, display, front porch, starting at h_cnt=0. Frame order is the same, starting at v_cnt=0.
- Horizontal decode:
  - hsync = HSYNC_POL for h_cnt < H_SYNCPULSE, else the inverse.
  - The h display region is HS0 ≤ h_cnt ≤ HS0+H_DISPLAY-1 (inclusive bounds).
- Vertical decode is the same, using v_cnt and the V parameters.
- Advance, on an edge with en=1 and resync=0:
  - If h_cnt = H_TOTAL-1, then h_cnt←0. v_cnt increments, wrapping from V_TOTAL-1 to 0.
  - Otherwise h_cnt increments and v_cnt holds.
- With en=0 and resync=0, all counters and decoded outputs hold. line_start and frame_start drop to 0.
- resync=1 takes priority over en: h_cnt←0, v_cnt←0, line_start←1, frame_start←1.
- line_start is 1 for exactly one clk cycle after h_cnt wraps to 0. frame_start is 1 for exactly one cycle when v_cnt also wraps. A pulse is never stretched, even if en stays 0.
- All outputs are registered. They always equal the decode of the h_cnt/v_cnt values presented in the same cycle; the implementation decodes next-state values.
- Arithmetic is unsigned in CW bits. Parameters are constant. A parameter set where H_TOTAL or V_TOTAL exceeds 2^CW is illegal; the block checks this at elaboration via $error in a generate.

## Timing

- Reset (rst_n=0) acts asynchronously:
  - h_cnt=0, v_cnt=0, x=0, y=0, display=0
  - hsync=HSYNC_POL, vsync=VSYNC_POL
  - line_start=0, frame_start=0
- Reset produces no start pulses. The first line_start occurs at the first wrap or resync.
- Latency from an en=1 edge to updated outputs is one clk. Decoded outputs never lag the counters.
- With en held at 1, the line period is H_TOTAL clk cycles and the frame period is H_TOTAL×V_TOTAL clk cycles (420000 with defaults).
- resync arriving in the same cycle as a natural wrap produces one pulse, not two.
- Reset deasserted mid-frame restarts the raster at (0,0) with hsync and vsync active.

## Test plan

- Reset: hold rst_n=0 with en toggling. Required: h_cnt=v_cnt=0, hsync=vsync=1, display=0, no pulses. Release, with en=1 constant: h_cnt=1 after the first edge.
- Line timing, defaults, en=1:
  - hsync=1 for h_cnt 0..95, 0 for 96..799.
  - On a visible line, display=1 exactly for h_cnt 144..783, with x running 0..639.
  - line_start pulses every 800 cycles.
- Frame timing:
  - vsync=1 for v_cnt 0..1.
  - display=1 only on v_cnt 35..514, with y 0..479.
  - frame_start every 420000 cycles.
  - After frame_start, v_cnt=0 and h_cnt=0.
- en at 1-in-4 duty: the line takes 3200 clk. Outputs hold between ticks, and line_start is high for one clk only.
- resync asserted at h_cnt=300, v_cnt=100:
  - Next cycle: (0,0) with line_start=frame_start=1.
  - resync asserted at h_cnt=799 on the final line gives a single pulse pair.
- Small configuration, H 1/1/2/1 and V 1/1/2/1 with HSYNC_POL=VSYNC_POL=0:
  - H_TOTAL=5. hsync=0 only at h_cnt=0.
  - display=1 only at (2..3, 2..3).
  - Reset asserted mid-line returns to (0,0) immediately.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator producing registered syncs,
// display enable, pixel coordinates and line/frame start pulses.
module vga_timing_gen #(
  parameter int   H_SYNCPULSE = 96,
  parameter int   H_BPORCH    = 48,
  parameter int   H_DISPLAY   = 640,
  parameter int   H_FPORCH    = 16,
  parameter int   V_SYNCPULSE = 2,
  parameter int   V_BPORCH    = 33,
  parameter int   V_DISPLAY   = 480,
  parameter int   V_FPORCH    = 10,
  parameter logic HSYNC_POL   = 1'b1,
  parameter logic VSYNC_POL   = 1'b1,
  parameter int   CW          = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          resync,
  output logic          hsync,
  output logic          vsync,
  output logic          display,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);
  localparam int H_TOTAL = H_SYNCPULSE + H_BPORCH + H_DISPLAY + H_FPORCH;
  localparam int V_TOTAL = V_SYNCPULSE + V_BPORCH + V_DISPLAY + V_FPORCH;
  localparam int HS0 = H_SYNCPULSE + H_BPORCH;
  localparam int VS0 = V_SYNCPULSE + V_BPORCH;
  localparam int HE = HS0 + H_DISPLAY - 1;
  localparam int VE = VS0 + V_DISPLAY - 1;

  if (H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end

  logic [CW-1:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
  logic hs_q, hs_d, vs_q, vs_d, disp_q, disp_d, ls_q, ls_d, fs_q, fs_d;
  logic h_wrap, v_wrap, h_vis, v_vis;

  // Outputs are decoded from the next-state counters so they never lag h_cnt/v_cnt.
  always_comb begin
    h_wrap = h_q == CW'(H_TOTAL - 1);
    v_wrap = v_q == CW'(V_TOTAL - 1);
    h_d    = resync ? '0 : en ? (h_wrap ? '0 : h_q + 1'b1) : h_q;
    v_d    = resync ? '0 : (en && h_wrap) ? (v_wrap ? '0 : v_q + 1'b1) : v_q;
    ls_d   = resync | (en & h_wrap);
    fs_d   = resync | (en & h_wrap & v_wrap);
    h_vis  = h_d >= CW'(HS0) && h_d <= CW'(HE);
    v_vis  = v_d >= CW'(VS0) && v_d <= CW'(VE);
    disp_d = h_vis & v_vis;
    x_d    = disp_d ? h_d - CW'(HS0) : '0;
    y_d    = disp_d ? v_d - CW'(VS0) : '0;
    hs_d   = h_d < CW'(H_SYNCPULSE) ? HSYNC_POL : ~HSYNC_POL;
    vs_d   = v_d < CW'(V_SYNCPULSE) ? VSYNC_POL : ~VSYNC_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q    <= '0;
      v_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      disp_q <= 1'b0;
      hs_q   <= HSYNC_POL;
      vs_q   <= VSYNC_POL;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      x_q    <= x_d;
      y_q    <= y_d;
      disp_q <= disp_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign x           = x_q;
  assign y           = y_q;
  assign display     = disp_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks default, mid-size and tiny raster configurations against a
// position-index model of the raster, plus a small hand-written vector table.
module tb_vga_timing_gen;
  typedef struct packed {
    logic [10:0] h, v, x, y;
    logic hs, vs, d, ls, fs;
  } obs_t;
  typedef struct {
    int hsp, hbp, hd, hfp, vsp, vbp, vd, vfp;
    bit hp, vp;
  } cfg_t;
  typedef struct {
    logic rst, en, rs;
    obs_t exp;
  } vec_t;

  logic clk, rst_n;
  logic en_a[3], rs_a[3];
  logic hs_o[3], vs_o[3], dp_o[3], ls_o[3], fs_o[3];
  logic [10:0] h_o[3], v_o[3], x_o[3], y_o[3];
  obs_t got[3];
  cfg_t cfg[3];
  string names[3];
  int pos[3];
  bit mls[3], mfs[3];
  int checks = 0, failures = 0, cyc = 0;
  vec_t vecs[$];

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .en(en_a[0]), .resync(rs_a[0]),
    .hsync(hs_o[0]), .vsync(vs_o[0]), .display(dp_o[0]), .h_cnt(h_o[0]), .v_cnt(v_o[0]),
    .x(x_o[0]), .y(y_o[0]), .line_start(ls_o[0]), .frame_start(fs_o[0]));

  vga_timing_gen #(.H_SYNCPULSE(8), .H_BPORCH(4), .H_DISPLAY(20), .H_FPORCH(4),
    .V_SYNCPULSE(2), .V_BPORCH(3), .V_DISPLAY(10), .V_FPORCH(2),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)) u_mid (
    .clk(clk), .rst_n(rst_n), .en(en_a[1]), .resync(rs_a[1]),
    .hsync(hs_o[1]), .vsync(vs_o[1]), .display(dp_o[1]), .h_cnt(h_o[1]), .v_cnt(v_o[1]),
    .x(x_o[1]), .y(y_o[1]), .line_start(ls_o[1]), .frame_start(fs_o[1]));

  vga_timing_gen #(.H_SYNCPULSE(1), .H_BPORCH(1), .H_DISPLAY(2), .H_FPORCH(1),
    .V_SYNCPULSE(1), .V_BPORCH(1), .V_DISPLAY(2), .V_FPORCH(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) u_small (
    .clk(clk), .rst_n(rst_n), .en(en_a[2]), .resync(rs_a[2]),
    .hsync(hs_o[2]), .vsync(vs_o[2]), .display(dp_o[2]), .h_cnt(h_o[2]), .v_cnt(v_o[2]),
    .x(x_o[2]), .y(y_o[2]), .line_start(ls_o[2]), .frame_start(fs_o[2]));

  for (genvar g = 0; g < 3; g++) begin : g_obs
    assign got[g] = {h_o[g], v_o[g], x_o[g], y_o[g], hs_o[g], vs_o[g], dp_o[g], ls_o[g], fs_o[g]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int htot(cfg_t c);
    return c.hsp + c.hbp + c.hd + c.hfp;
  endfunction

  function automatic int ftot(cfg_t c);
    return htot(c) * (c.vsp + c.vbp + c.vd + c.vfp);
  endfunction

  // Expected outputs for linear raster position p (pixels since the frame origin).
  function automatic obs_t model(cfg_t c, int p, bit ls, bit fs);
    int ht = htot(c);
    int h = p % ht;
    int v = p / ht;
    int hs0 = c.hsp + c.hbp;
    int vs0 = c.vsp + c.vbp;
    bit d = h >= hs0 && h < hs0 + c.hd && v >= vs0 && v < vs0 + c.vd;
    obs_t o;
    o.h = 11'(h);
    o.v = 11'(v);
    o.x = d ? 11'(h - hs0) : 11'd0;
    o.y = d ? 11'(v - vs0) : 11'd0;
    o.hs = h < c.hsp ? c.hp : !c.hp;
    o.vs = v < c.vsp ? c.vp : !c.vp;
    o.d = d;
    o.ls = ls;
    o.fs = fs;
    return o;
  endfunction

  function automatic void chk(string name, obs_t g, obs_t e);
    checks++;
    if (g !== e) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %h expected %h at cycle %0d", name, g, e, cyc);
    end
  endfunction

  function automatic void chk_i(string name, int g, int e);
    checks++;
    if (g != e) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0d expected %0d at cycle %0d", name, g, e, cyc);
    end
  endfunction

  function automatic vec_t mkv(logic r, logic e, logic s, int h, int v, bit hs, bit vs,
                               bit d, int xx, int yy, bit ls, bit fs);
    vec_t t;
    t.rst = r; t.en = e; t.rs = s;
    t.exp = {11'(h), 11'(v), 11'(xx), 11'(yy), hs, vs, d, ls, fs};
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        pos[i] = 0; mls[i] = 0; mfs[i] = 0;
      end else if (rs_a[i]) begin
        pos[i] = 0; mls[i] = 1; mfs[i] = 1;
      end else if (en_a[i]) begin
        pos[i] = (pos[i] + 1) % ftot(cfg[i]);
        mls[i] = pos[i] % htot(cfg[i]) == 0;
        mfs[i] = pos[i] == 0;
      end else begin
        mls[i] = 0; mfs[i] = 0;
      end
      chk(names[i], got[i], model(cfg[i], pos[i], mls[i], mfs[i]));
    end
  endtask

  task automatic set_all(logic e, logic s);
    for (int i = 0; i < 3; i++) begin
      en_a[i] = e; rs_a[i] = s;
    end
  endtask

  initial begin
    int last, n;
    cfg[0] = '{96, 48, 640, 16, 2, 33, 480, 10, 1'b1, 1'b1};
    cfg[1] = '{8, 4, 20, 4, 2, 3, 10, 2, 1'b0, 1'b1};
    cfg[2] = '{1, 1, 2, 1, 1, 1, 2, 1, 1'b0, 1'b0};
    names[0] = "def"; names[1] = "mid"; names[2] = "small";
    rst_n = 1'b0;
    set_all(1'b0, 1'b0);
    // reset held with en toggling
    for (int k = 0; k < 4; k++) begin
      set_all(logic'(k % 2), 1'b0);
      tick();
    end
    chk_i("rst_hsync", int'(hs_o[0]), 1);
    chk_i("rst_display", int'(dp_o[0]), 0);
    // tiny-config vector table
    vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mkv(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 2, 1, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 3, 1, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 4, 1, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 0, 2, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mkv(1, 1, 0, 1, 2, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 2, 2, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 3, 2, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mkv(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mkv(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    set_all(1'b0, 1'b0);
    foreach (vecs[k]) begin
      rst_n = vecs[k].rst; en_a[2] = vecs[k].en; rs_a[2] = vecs[k].rs;
      tick();
      chk($sformatf("vec%0d", k), got[2], vecs[k].exp);
    end
    set_all(1'b0, 1'b0);
    // default config: first edge after reset, then run into the visible region
    en_a[0] = 1'b1;
    tick();
    chk_i("def_first_h", int'(h_o[0]), 1);
    last = -1;
    for (n = 0; n < 40000 && !(h_o[0] == 0 && v_o[0] == 36); n++) begin
      tick();
      if (ls_o[0]) begin
        if (last >= 0) chk_i("def_line_period", cyc - last, 800);
        last = cyc;
      end
      if (v_o[0] == 35 && h_o[0] == 783) chk_i("def_x_last", int'(x_o[0]), 639);
      if (v_o[0] == 35 && h_o[0] == 144) chk_i("def_disp_first", int'(dp_o[0]), 1);
    end
    chk_i("def_reach_v36", int'(h_o[0] == 0 && v_o[0] == 36), 1);
    // 1-in-4 pixel enable
    last = -1;
    for (int k = 0; k < 8000; k++) begin
      en_a[0] = logic'(k % 4 == 0);
      tick();
      if (ls_o[0]) begin
        if (last >= 0) chk_i("def_duty_period", cyc - last, 3200);
        last = cyc;
      end
    end
    en_a[0] = 1'b1;
    for (n = 0; n < 1000 && h_o[0] != 300; n++) tick();
    chk_i("def_reach_h300", int'(h_o[0]), 300);
    rs_a[0] = 1'b1;
    tick();
    rs_a[0] = 1'b0;
    chk_i("def_rs_pulses", int'({ls_o[0], fs_o[0]}), 3);
    chk_i("def_rs_pos", int'({h_o[0], v_o[0]}), 0);
    en_a[0] = 1'b0;
    // mid config: frame period and resync on the final pixel
    en_a[1] = 1'b1;
    last = -1;
    for (int k = 0; k < 1300; k++) begin
      tick();
      if (fs_o[1]) begin
        if (last >= 0) chk_i("mid_frame_period", cyc - last, 612);
        chk_i("mid_fs_pos", int'({h_o[1], v_o[1]}), 0);
        last = cyc;
      end
    end
    for (n = 0; n < 700 && !(h_o[1] == 35 && v_o[1] == 16); n++) tick();
    chk_i("mid_reach_last", int'(h_o[1] == 35 && v_o[1] == 16), 1);
    rs_a[1] = 1'b1;
    tick();
    rs_a[1] = 1'b0;
    chk_i("mid_rs_wrap_pulse", int'({ls_o[1], fs_o[1]}), 3);
    tick();
    chk_i("mid_rs_single", int'({ls_o[1], fs_o[1]}), 0);
    en_a[1] = 1'b0;
    // tiny config: full frames, then resync on the final pixel
    en_a[2] = 1'b1;
    for (int k = 0; k < 60; k++) tick();
    for (n = 0; n < 30 && !(h_o[2] == 4 && v_o[2] == 4); n++) tick();
    rs_a[2] = 1'b1;
    tick();
    rs_a[2] = 1'b0;
    chk_i("small_rs_wrap_pulse", int'({ls_o[2], fs_o[2]}), 3);
    // randomized en/resync on all instances
    for (int k = 0; k < 6000; k++) begin
      for (int i = 0; i < 3; i++) begin
        en_a[i] = logic'($urandom_range(0, 2) != 0);
        rs_a[i] = logic'($urandom_range(0, 299) == 0);
      end
      tick();
    end
    // asynchronous reset mid-line
    set_all(1'b1, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      pos[i] = 0; mls[i] = 0; mfs[i] = 0;
      chk({names[i], "_async_rst"}, got[i], model(cfg[i], 0, 0, 0));
    end
    chk_i("small_async_hs", int'(hs_o[2]), 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk_i("def_after_async_h", int'(h_o[0]), 1);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
